// File: rtl/sdram_bus_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdram_bus_master: turns local single requests into SDRAM ACT/CAS/burst   |
// | command sequences. Optional write-stall support: SDRAM_MASTER_STALL_EN.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sdram_bus_master #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    output logic              req_ready,
    output logic              done,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              CS,
    output logic              RAS,
    output logic              CAS,
    output logic              WeIn,
    output logic [31:0]       AddrOut,
    output logic [1:0]        SizeOut,
    output logic [DATA_W-1:0] DataOut,
    input  logic [DATA_W-1:0] DataIn,
    input  logic [7:0]        tburst,
    input  logic [3:0]        tlat,
    input  logic [7:0]        tcas,
    input  logic [7:0]        twait
`ifndef SDRAM_MASTER_STALL_EN
    ,
    output logic              underrun
`endif
);

    localparam logic [3:0] C_NOP   = 4'b1111;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_WRITE = 4'b0100;
    localparam logic [3:0] C_READ  = 4'b0101;
`ifdef SDRAM_MASTER_STALL_EN
    localparam logic [3:0] C_STALL = 4'b1100;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACT    = 3'd1,
        S_CASW   = 3'd2,
        S_CMD    = 3'd3,
        S_WBURST = 3'd4,
        S_RLAT   = 3'd5,
        S_RBURST = 3'd6,
        S_REC    = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          w_cmd;
    logic                w_beat_adv;
    logic                r_we;
    logic [7:0]          r_cnt;
    logic [7:0]          r_beat;
    logic [7:0]          r_tburst;
    logic [3:0]          r_tlat;
    logic [7:0]          r_tcas;
    logic [7:0]          r_twait;
    logic [31:0]         r_addr;
    logic [1:0]          r_size;
    logic [DATA_W-1:0]   r_dout;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;

    // Without stall support every burst cycle consumes a beat slot.
`ifdef SDRAM_MASTER_STALL_EN
    assign w_beat_adv = wr_valid;
`else
    assign w_beat_adv = 1'b1;
    assign underrun   = (r_state == S_WBURST) && !wr_valid;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_cmd  = C_NOP;
        case (r_state)
            S_IDLE:   if (req) w_next = S_ACT;
            S_ACT: begin
                w_cmd  = C_ACT;
                w_next = S_CASW;
            end
            S_CASW:   if (r_cnt == 8'd1) w_next = S_CMD;
            S_CMD: begin
                w_cmd = r_we ? C_WRITE : C_READ;
                if (r_we)               w_next = S_WBURST;
                else if (r_tlat != 4'd0) w_next = S_RLAT;
                else                    w_next = S_RBURST;
            end
            S_WBURST: begin
                w_cmd = C_WRITE;
`ifdef SDRAM_MASTER_STALL_EN
                if (!wr_valid) w_cmd = C_STALL;
`endif
                if (w_beat_adv && (r_beat == 8'd1)) w_next = S_REC;
            end
            S_RLAT: begin
                w_cmd = C_READ;
                if (r_cnt == 8'd1) w_next = S_RBURST;
            end
            S_RBURST: begin
                w_cmd = C_READ;
                if (r_beat == 8'd1) w_next = S_REC;
            end
            S_REC:    if (r_cnt == 8'd1) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_we       <= 1'b0;
            r_cnt      <= 8'd0;
            r_beat     <= 8'd0;
            r_tburst   <= 8'd1;
            r_tlat     <= 4'd0;
            r_tcas     <= 8'd1;
            r_twait    <= 8'd1;
            r_addr     <= 32'd0;
            r_size     <= 2'd0;
            r_dout     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we     <= req_we;
                        r_addr   <= req_addr;
                        r_size   <= req_size;
                        r_tburst <= (tburst == 8'd0) ? 8'd1 : tburst;
                        r_tlat   <= tlat;
                        r_tcas   <= (tcas == 8'd0) ? 8'd1 : tcas;
                        r_twait  <= (twait == 8'd0) ? 8'd1 : twait;
                    end
                end
                S_ACT:  r_cnt <= r_tcas;
                S_CMD: begin
                    r_beat <= r_tburst;
                    r_cnt  <= {4'd0, r_tlat};
                end
                S_WBURST: begin
                    if (w_beat_adv) r_beat <= r_beat - 8'd1;
                    if (wr_valid)   r_dout <= wr_data;
                end
                S_RBURST: begin
                    r_rd_data  <= DataIn;
                    r_rd_valid <= 1'b1;
                    r_beat     <= r_beat - 8'd1;
                end
                default: r_cnt <= r_cnt - 8'd1;
            endcase
            // Recovery count is loaded on entry, overriding the branch above.
            if ((w_next == S_REC) && (r_state != S_REC)) r_cnt <= r_twait;
        end
    end

    assign {CS, RAS, CAS, WeIn} = w_cmd;
    assign req_ready = (r_state == S_IDLE);
    assign done      = (r_state == S_REC) && (r_cnt == 8'd1);
    assign wr_ready  = (r_state == S_WBURST) && wr_valid;
    assign AddrOut   = r_addr;
    assign SizeOut   = r_size;
    assign DataOut   = r_dout;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_sdram_bus_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sdram_bus_master: directed bench for sdram_bus_master (either build   |
// | of SDRAM_MASTER_STALL_EN).                                               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sdram_bus_master;

    localparam logic [3:0] NOP = 4'hF;
    localparam logic [3:0] ACT = 4'h3;
    localparam logic [3:0] WR  = 4'h4;
    localparam logic [3:0] RD  = 4'h5;
    localparam logic [3:0] STL = 4'hC;

    logic        Clk = 1'b0;
    logic        Rst, req, req_we, req_ready, done;
    logic [31:0] req_addr, AddrOut, wr_data, rd_data, DataOut, DataIn;
    logic [1:0]  req_size, SizeOut;
    logic        wr_valid, wr_ready, rd_valid;
    logic        CS, RAS, CAS, WeIn;
    logic [7:0]  tburst, tcas, twait;
    logic [3:0]  tlat;
    logic        underrun;
    logic [3:0]  cmd;

    int checks   = 0;
    int failures = 0;
    int nb, nv, nrdy, nund, nstl;

    logic [3:0] exp_w [1:11] = '{ACT, NOP, NOP, WR, WR, WR, WR, WR, NOP, NOP, NOP};
    logic [3:0] exp_r [1:9]  = '{ACT, NOP, RD, RD, RD, RD, RD, NOP, NOP};
    logic [3:0] exp_z [1:6]  = '{ACT, NOP, RD, RD, NOP, NOP};
    logic [3:0] exp_m [1:6]  = '{ACT, NOP, WR, WR, NOP, NOP};
`ifdef SDRAM_MASTER_STALL_EN
    logic [3:0] exp_s [1:10] = '{ACT, NOP, WR, WR, STL, STL, WR, WR, NOP, NOP};
    int         s_done = 9;
    int         s_rdy  = 3;
    int         s_stl  = 2;
`else
    logic [3:0] exp_s [1:10] = '{ACT, NOP, WR, WR, WR, WR, NOP, NOP, NOP, NOP};
    int         s_done = 7;
    int         s_rdy  = 1;
    int         s_stl  = 0;
`endif

    always #5 Clk = ~Clk;
    assign cmd = {CS, RAS, CAS, WeIn};

    sdram_bus_master #(.DATA_W(32)) dut (
        .Clk(Clk), .Rst(Rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_size(req_size), .req_ready(req_ready), .done(done),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .CS(CS), .RAS(RAS), .CAS(CAS), .WeIn(WeIn),
        .AddrOut(AddrOut), .SizeOut(SizeOut), .DataOut(DataOut), .DataIn(DataIn),
        .tburst(tburst), .tlat(tlat), .tcas(tcas), .twait(twait)
`ifndef SDRAM_MASTER_STALL_EN
        , .underrun(underrun)
`endif
    );

`ifdef SDRAM_MASTER_STALL_EN
    assign underrun = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        Rst = 1'b0; req = 1'b1; req_we = 1'b0; req_addr = 32'hFFFF_FFFF; req_size = 2'd3;
        wr_data = '0; wr_valid = 1'b0; DataIn = '0;
        tburst = 8'd0; tlat = 4'd0; tcas = 8'd0; twait = 8'd0;

        // Reset held with a pending request
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("rst_cmd", cmd, NOP);
            chk("rst_ready", req_ready, 1);
            chk("rst_addr", AddrOut, 0);
            chk("rst_done", done, 0);
        end
        Rst = 1'b1; req = 1'b0;
        cyc(); #1;
        chk("idle_ready", req_ready, 1);

        // Write: tcas=2 tburst=4 twait=3
        tcas = 8'd2; tburst = 8'd4; twait = 8'd3;
        req = 1'b1; req_we = 1'b1; req_addr = 32'h0000_1234; req_size = 2'b10; wr_valid = 1'b1;
        nb = 0;
        for (int k = 1; k <= 11; k++) begin
            cyc(); req = 1'b0; wr_data = 32'hA0 + nb; #1;
            chk("wr_cmd", cmd, exp_w[k]);
            chk("wr_done", done, k == 11);
            if (k >= 6 && k <= 9) chk("wr_dout", DataOut, 32'hA0 + k - 6);
            if (wr_ready) nb++;
        end
        chk("wr_beats", nb, 4);
        chk("wr_addr", AddrOut, 32'h0000_1234);
        chk("wr_size", SizeOut, 2'b10);
        cyc(); #1;
        chk("wr_back_idle", req_ready, 1);

        // Read: tlat=2 tburst=2 with cycle-stamped DataIn
        tcas = 8'd1; tburst = 8'd2; twait = 8'd1; tlat = 4'd2;
        req = 1'b1; req_we = 1'b0; req_addr = 32'h0000_5678; req_size = 2'b01; wr_valid = 1'b0;
        nv = 0;
        for (int k = 1; k <= 9; k++) begin
            cyc(); req = 1'b0; DataIn = 32'hD000_0000 + k; #1;
            chk("rd_cmd", cmd, exp_r[k]);
            chk("rd_done", done, k == 8);
            chk("rd_valid", rd_valid, (k == 7) || (k == 8));
            if (rd_valid) begin
                chk("rd_data", rd_data, 32'hD000_0000 + k - 1);
                nv++;
            end
        end
        chk("rd_beats", nv, 2);

        // All timing values zero, read with tlat=0
        tcas = 8'd0; tburst = 8'd0; twait = 8'd0; tlat = 4'd0;
        req = 1'b1; req_we = 1'b0;
        nv = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc(); req = 1'b0; DataIn = 32'hE000_0000 + k; #1;
            chk("z_cmd", cmd, exp_z[k]);
            chk("z_done", done, k == 5);
            if (rd_valid) begin
                chk("z_data", rd_data, 32'hE000_0004);
                nv++;
            end
        end
        chk("z_beats", nv, 1);

        // Write with wr_valid low for two cycles after the first beat
        tcas = 8'd1; tburst = 8'd3; twait = 8'd1;
        req = 1'b1; req_we = 1'b1;
        nb = 0; nrdy = 0; nund = 0; nstl = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(); req = 1'b0; wr_valid = !((k == 5) || (k == 6)); wr_data = 32'hA0 + nb; #1;
            chk("st_cmd", cmd, exp_s[k]);
            chk("st_done", done, k == s_done);
            if (k >= 5 && k <= 7) chk("st_dout", DataOut, 32'hA0);
            if (cmd == STL) nstl++;
            if (underrun) nund++;
            if (wr_ready) begin
                nrdy++;
                nb++;
            end
        end
        chk("st_stalls", nstl, s_stl);
        chk("st_ready", nrdy, s_rdy);
        chk("st_underrun", nund, 2 - s_stl);
        wr_valid = 1'b0;

        // Reset during a read burst, then a minimal write
        tcas = 8'd1; tburst = 8'd4; twait = 8'd1; tlat = 4'd0;
        req = 1'b1; req_we = 1'b0; req_addr = 32'h0000_9ABC;
        for (int k = 1; k <= 5; k++) begin
            cyc(); req = 1'b0; DataIn = 32'hF000_0000 + k; #1;
            if (k == 5) chk("mr_valid_pre", rd_valid, 1);
        end
        Rst = 1'b0;
        cyc(); #1;
        chk("mr_cmd", cmd, NOP);
        chk("mr_valid", rd_valid, 0);
        chk("mr_ready", req_ready, 1);
        chk("mr_addr", AddrOut, 0);
        chk("mr_rdata", rd_data, 0);
        Rst = 1'b1;
        tburst = 8'd1; req = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0040; wr_valid = 1'b1; wr_data = 32'h55;
        for (int k = 1; k <= 6; k++) begin
            cyc(); req = 1'b0; #1;
            chk("mr_cmd2", cmd, exp_m[k]);
            chk("mr_done", done, k == 5);
        end
        chk("mr_dout", DataOut, 32'h55);
        chk("mr_addr2", AddrOut, 32'h0000_0040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
